instr_fetch: RTL and testbench
==============================

Name: instr_fetch

Overview:
- Single-clock, pipelined instruction fetch stage feeding the decode stage.
- Drives RAM read port B (enb/addrb, dob returns one cycle after the address is sampled).
- Assembles two-word instructions (word0 = op[15:8] | arg[7:0], word1 = 16-bit immediate) into a small queue and presents them to decode with a valid/ready handshake.
- Accepts redirects (JMP) from decode and flushes stale work.

Parameters:
- ADDR_W, 10, RAM word-address width.
- DATA_W, 16, RAM word width.
- QDEPTH, 2, instruction queue entries (power of two, >=2).
- RESET_PC, 0, fetch address after reset.

Ports:
- clkb  in  1  clock; shared with RAM read port B.
- rst  in  1  reset.
- enb  out  1  RAM read enable.
- addrb  out  ADDR_W  RAM read address.
- dob  in  DATA_W  RAM read data, valid the cycle after enb/addrb were sampled.
- instr_valid  out  1  queue head holds a complete instruction.
- instr_ready  in  1  decode accepts the head this cycle.
- instr_op  out  8  head word0[15:8].
- instr_arg  out  8  head word0[7:0] (register number).
- instr_imm  out  DATA_W  head word1.
- instr_pc  out  ADDR_W  address of head word0.
- redirect  in  1  decode requests a fetch restart.
- redirect_addr  in  ADDR_W  restart address.

Behaviour:
- Clock and reset: one clock, clkb. Reset rst is synchronous, active-high.
- Reset values (at any edge with rst=1, including mid-fetch):
  - enb=0, addrb=0, instr_valid=0, instr_op/arg/imm/pc=0.
  - fetch_pc=RESET_PC, queue empty, in-flight tracking cleared, epoch=0.
- Read pipeline: enb/addrb are registered.
  - Issue at edge k: addrb=A visible after k.
  - RAM samples at edge k+1.
  - Block captures dob at edge k+2.
  - At most one word is issued per cycle; each issue increments fetch_pc modulo 2^ADDR_W. Address 1023 wraps to 0, so an instruction may straddle the wrap.
- Phase: a phase bit alternates LO/HI per issued word. Each in-flight word carries {phase, epoch, pc} in a 2-deep shift pipeline matching RAM latency.
- Credit:
  - A LO word is issued only if (queue occupancy + instructions in flight) < QDEPTH.
  - A HI word is always issued immediately after its LO.
  - When credit is blocked, enb=0 and addrb holds.
- Assembly:
  - A captured LO word goes to a holding register with its pc.
  - A captured HI word plus the held LO is pushed to the queue in the same edge.
  - A push with a full queue cannot occur by construction; the bench asserts this.
- Handshake:
  - Dequeue when instr_valid & instr_ready at an edge.
  - Outputs are stable while instr_valid=1 and instr_ready=0.
  - Simultaneous push and pop keeps occupancy unchanged.
- Latency: first non-reset edge E0 issues RESET_PC. instr_valid rises after E0+3. Peak throughput is 1 instruction per 2 cycles.
- Redirect at edge r (priority over everything except rst):
  - fetch_pc=redirect_addr (odd or even both legal); addrb=redirect_addr after r with enb=1.
  - Queue flushed; instr_valid=0 after r. A pop in the same edge is irrelevant because everything is flushed.
  - Holding register cleared, phase=LO, epoch toggles.
  - Captured words whose epoch differs from the current epoch are discarded and release their credit.
  - First post-redirect instruction becomes valid after r+3.
  - A redirect during cycle r+1 repeats the sequence; the epoch toggles again and no stale word is ever delivered.
- State machine (issue control):
  - RESET → ISSUE_LO.
  - ISSUE_LO → ISSUE_HI when credit is available, else stay (enb=0).
  - ISSUE_HI → ISSUE_LO.
  - Any state → ISSUE_LO on redirect, with addrb=redirect_addr.

Decomposition:
- Shared include cpu_defines.vh holds:
  - opcode constants (JMP=1, RAM2REG=2, REG2RAM=3, NUM2REG=4);
  - ADDR_W/DATA_W defaults;
  - issue-state encodings (ISSUE_LO=0, ISSUE_HI=1).
- One natural sub-module, fetch_queue: synchronous FIFO, QDEPTH x (8+8+DATA_W+ADDR_W), with push/pop/flush/count ports.

Test Plan:
- Reset then free-run. RAM[0]=0x0405, RAM[1]=0x1234, ready=1 → after E0+3: op=4, arg=5, imm=0x1234, pc=0. Next instruction pc=2, two cycles later.
- Backpressure. instr_ready=0 for 10 cycles from reset → queue fills to 2 (pcs 0 and 2), enb=0 thereafter, outputs frozen. Release → pcs 0, 2, 4 in order, none skipped or duplicated.
- Redirect. Assert redirect with redirect_addr=0x100 while words from pc 4–6 are in flight → nothing from pc≥4 is delivered. Next valid has pc=0x100 exactly 3 edges later.
- Back-to-back redirect. redirect_addr=0x10, then 0x20 on the following cycle → first delivered pc=0x20; no 0x10 instruction appears.
- Wrap. redirect_addr=1023, RAM[1023]=0x0203, RAM[0]=0x0055 → op=2, arg=3, imm=0x0055, pc=1023. Next pc=1.
- Mid-operation reset. rst=1 for one edge while queue is full and reads are in flight → outputs zero and instr_valid=0 next cycle. Fetch restarts at RESET_PC with E0 timing.

Source files
------------

// File: rtl/instr_fetch_pkg.sv
// Shared definitions for the instruction fetch stage: opcodes, default widths
// and the issue-control state encoding.
package instr_fetch_pkg;

    localparam int DEF_ADDR_W = 10;
    localparam int DEF_DATA_W = 16;

    localparam logic [7:0] OP_JMP     = 8'd1;
    localparam logic [7:0] OP_RAM2REG = 8'd2;
    localparam logic [7:0] OP_REG2RAM = 8'd3;
    localparam logic [7:0] OP_NUM2REG = 8'd4;

    typedef enum logic {
        ISSUE_LO = 1'b0,
        ISSUE_HI = 1'b1
    } issue_state_e;

endpackage

// File: rtl/fetch_queue.sv
// Small synchronous FIFO holding assembled instructions; flush empties it in one edge.
module fetch_queue #(
    parameter int DEPTH = 2,
    parameter int W     = 42
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  logic [W-1:0]           push_data,
    input  logic                   pop,
    input  logic                   flush,
    output logic [W-1:0]           head_data,
    output logic [$clog2(DEPTH):0] count
);
    localparam int PW = $clog2(DEPTH);

    logic [W-1:0]  mem_q [DEPTH];
    logic [PW-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [PW:0]   count_q, count_d;
    logic          do_pop;

    always_comb begin
        do_pop   = pop && (count_q != '0);
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (flush) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push)   wr_ptr_d = wr_ptr_q + PW'(1);
            if (do_pop) rd_ptr_d = rd_ptr_q + PW'(1);
            count_d = count_q + (PW+1)'(push) - (PW+1)'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push && !flush && !rst) mem_q[wr_ptr_q] <= push_data;
    end

    assign head_data = mem_q[rd_ptr_q];
    assign count     = count_q;

endmodule

// File: rtl/instr_fetch.sv
// Pipelined fetch stage: issues word reads to RAM port B, pairs LO/HI words into
// instructions, queues them for decode and restarts cleanly on redirect.
module instr_fetch
    import instr_fetch_pkg::*;
#(
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int DATA_W   = DEF_DATA_W,
    parameter int QDEPTH   = 2,
    parameter int RESET_PC = 0
) (
    input  logic              clkb,
    input  logic              rst,
    output logic              enb,
    output logic [ADDR_W-1:0] addrb,
    input  logic [DATA_W-1:0] dob,
    output logic              instr_valid,
    input  logic              instr_ready,
    output logic [7:0]        instr_op,
    output logic [7:0]        instr_arg,
    output logic [DATA_W-1:0] instr_imm,
    output logic [ADDR_W-1:0] instr_pc,
    input  logic              redirect,
    input  logic [ADDR_W-1:0] redirect_addr
);
    localparam int CW = $clog2(QDEPTH) + 1;
    localparam int EW = 16 + DATA_W + ADDR_W;

    issue_state_e            state_q, state_d;
    logic [ADDR_W-1:0]       fetch_pc_q, fetch_pc_d, addrb_q, addrb_d;
    logic                    enb_q, enb_d, epoch_q, epoch_d;
    logic [1:0]              pipe_vld_q, pipe_vld_d, pipe_phase_q, pipe_phase_d;
    logic [1:0]              pipe_epoch_q, pipe_epoch_d;
    logic [1:0][ADDR_W-1:0]  pipe_pc_q, pipe_pc_d;
    logic                    hold_vld_q, hold_vld_d;
    logic [15:0]             hold_word_q, hold_word_d;
    logic [ADDR_W-1:0]       hold_pc_q, hold_pc_d;
    logic [CW-1:0]           inflight_q, inflight_d;

    logic                    q_push, q_pop, q_flush, credit_ok, issue;
    logic [EW-1:0]           q_wdata, q_head;
    logic [CW-1:0]           q_count;

    always_comb begin
        state_d      = state_q;
        fetch_pc_d   = fetch_pc_q;
        addrb_d      = addrb_q;
        enb_d        = 1'b0;
        epoch_d      = epoch_q;
        hold_vld_d   = hold_vld_q;
        hold_word_d  = hold_word_q;
        hold_pc_d    = hold_pc_q;
        q_push       = 1'b0;
        q_flush      = 1'b0;
        q_wdata      = {hold_word_q, dob, hold_pc_q};
        q_pop        = instr_valid && instr_ready;
        pipe_vld_d   = {pipe_vld_q[0], 1'b0};
        pipe_phase_d = {pipe_phase_q[0], 1'b0};
        pipe_epoch_d = {pipe_epoch_q[0], 1'b0};
        pipe_pc_d[1] = pipe_pc_q[0];
        pipe_pc_d[0] = '0;

        // A slot freed by this edge's pop counts as available credit.
        credit_ok = (int'(q_count) - int'(q_pop) + int'(inflight_q)) < QDEPTH;

        // Words from an older epoch simply fall out of the pipe.
        if (pipe_vld_q[1] && (pipe_epoch_q[1] == epoch_q)) begin
            if (pipe_phase_q[1] == ISSUE_LO) begin
                hold_vld_d  = 1'b1;
                hold_word_d = dob[15:0];
                hold_pc_d   = pipe_pc_q[1];
            end else if (hold_vld_q) begin
                q_push     = 1'b1;
                hold_vld_d = 1'b0;
            end
        end

        issue = (state_q == ISSUE_HI) || credit_ok;
        if (issue) begin
            enb_d           = 1'b1;
            addrb_d         = fetch_pc_q;
            fetch_pc_d      = fetch_pc_q + ADDR_W'(1);
            pipe_vld_d[0]   = 1'b1;
            pipe_phase_d[0] = state_q;
            pipe_epoch_d[0] = epoch_q;
            pipe_pc_d[0]    = fetch_pc_q;
            state_d         = (state_q == ISSUE_LO) ? ISSUE_HI : ISSUE_LO;
        end
        inflight_d = inflight_q + CW'(issue && (state_q == ISSUE_LO)) - CW'(q_push);

        // Redirect issues the LO word at the target in the same edge, so the
        // next word owed is its HI half.
        if (redirect) begin
            q_flush         = 1'b1;
            q_push          = 1'b0;
            hold_vld_d      = 1'b0;
            epoch_d         = ~epoch_q;
            enb_d           = 1'b1;
            addrb_d         = redirect_addr;
            fetch_pc_d      = redirect_addr + ADDR_W'(1);
            pipe_vld_d[0]   = 1'b1;
            pipe_phase_d[0] = ISSUE_LO;
            pipe_epoch_d[0] = ~epoch_q;
            pipe_pc_d[0]    = redirect_addr;
            state_d         = ISSUE_HI;
            inflight_d      = CW'(1);
        end
    end

    always_ff @(posedge clkb) begin
        if (rst) begin
            state_q      <= ISSUE_LO;
            fetch_pc_q   <= ADDR_W'(RESET_PC);
            addrb_q      <= '0;
            enb_q        <= 1'b0;
            epoch_q      <= 1'b0;
            pipe_vld_q   <= '0;
            pipe_phase_q <= '0;
            pipe_epoch_q <= '0;
            pipe_pc_q    <= '0;
            hold_vld_q   <= 1'b0;
            hold_word_q  <= '0;
            hold_pc_q    <= '0;
            inflight_q   <= '0;
        end else begin
            state_q      <= state_d;
            fetch_pc_q   <= fetch_pc_d;
            addrb_q      <= addrb_d;
            enb_q        <= enb_d;
            epoch_q      <= epoch_d;
            pipe_vld_q   <= pipe_vld_d;
            pipe_phase_q <= pipe_phase_d;
            pipe_epoch_q <= pipe_epoch_d;
            pipe_pc_q    <= pipe_pc_d;
            hold_vld_q   <= hold_vld_d;
            hold_word_q  <= hold_word_d;
            hold_pc_q    <= hold_pc_d;
            inflight_q   <= inflight_d;
        end
    end

    fetch_queue #(.DEPTH(QDEPTH), .W(EW)) u_queue (
        .clk       (clkb),
        .rst       (rst),
        .push      (q_push),
        .push_data (q_wdata),
        .pop       (q_pop),
        .flush     (q_flush),
        .head_data (q_head),
        .count     (q_count)
    );

    assign enb         = enb_q;
    assign addrb       = addrb_q;
    assign instr_valid = (q_count != '0);
    // Head storage is not reset, so fields read as zero whenever nothing is valid.
    assign instr_op    = instr_valid ? q_head[EW-1 -: 8]      : '0;
    assign instr_arg   = instr_valid ? q_head[EW-9 -: 8]      : '0;
    assign instr_imm   = instr_valid ? q_head[ADDR_W +: DATA_W] : '0;
    assign instr_pc    = instr_valid ? q_head[0 +: ADDR_W]    : '0;

endmodule

// File: tb/tb_instr_fetch.sv
// Self-checking bench for instr_fetch: directed latency/boundary cases plus a
// randomized run scored against a program-order model of the RAM contents.
module tb_instr_fetch;
    localparam int ADDR_W   = 10;
    localparam int DATA_W   = 16;
    localparam int QDEPTH   = 2;
    localparam int RESET_PC = 0;

    logic              clkb = 1'b0;
    logic              rst, enb, instr_valid, instr_ready, redirect;
    logic [ADDR_W-1:0] addrb, instr_pc, redirect_addr;
    logic [DATA_W-1:0] dob, instr_imm;
    logic [7:0]        instr_op, instr_arg;

    logic [DATA_W-1:0] ram [1 << ADDR_W];
    logic [ADDR_W-1:0] exp_pc;
    int                n_chk = 0, n_pass = 0, n_deliv = 0, n;

    always #5 clkb = ~clkb;

    always @(posedge clkb) if (enb) dob <= ram[addrb];

    instr_fetch #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .QDEPTH(QDEPTH), .RESET_PC(RESET_PC)) dut (
        .clkb          (clkb),
        .rst           (rst),
        .enb           (enb),
        .addrb         (addrb),
        .dob           (dob),
        .instr_valid   (instr_valid),
        .instr_ready   (instr_ready),
        .instr_op      (instr_op),
        .instr_arg     (instr_arg),
        .instr_imm     (instr_imm),
        .instr_pc      (instr_pc),
        .redirect      (redirect),
        .redirect_addr (redirect_addr)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    endtask

    // One cycle: score the head against program order, then cross one edge.
    task automatic tick();
        logic [ADDR_W-1:0] pc1, r_addr;
        logic              was_rst, was_redir;
        #1;
        was_rst   = rst;
        was_redir = redirect;
        r_addr    = redirect_addr;
        if (!rst) begin
            chk("valid_known", 64'($isunknown(instr_valid)), 64'd0);
            chk("no_overflow", 64'(dut.q_push && (int'(dut.q_count) >= QDEPTH)), 64'd0);
            if (instr_valid === 1'b1) begin
                pc1 = exp_pc + ADDR_W'(1);
                chk("head", 64'({instr_op, instr_arg, instr_imm, instr_pc}),
                    64'({ram[exp_pc], ram[pc1], exp_pc}));
                if (instr_ready) begin
                    n_deliv++;
                    exp_pc = exp_pc + ADDR_W'(2);
                end
            end
            if (redirect) exp_pc = redirect_addr;
        end else begin
            exp_pc = ADDR_W'(RESET_PC);
        end
        @(posedge clkb);
        @(negedge clkb);
        if (was_rst)
            chk("rst_out", 64'({enb, addrb, instr_valid, instr_op, instr_arg, instr_imm, instr_pc}), 64'd0);
        else if (was_redir)
            chk("redir_out", 64'({instr_valid, enb, addrb}), 64'({1'b0, 1'b1, r_addr}));
    endtask

    task automatic wait_valid(input int max, output int cyc);
        cyc = -1;
        for (int i = 1; i <= max; i++) begin
            tick();
            if (instr_valid === 1'b1) begin
                cyc = i;
                break;
            end
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1; redirect = 1'b0; redirect_addr = '0; instr_ready = 1'b1;
        for (int i = 0; i < (1 << ADDR_W); i++) ram[i] = DATA_W'($urandom);
        ram[0] = 16'h0405;
        ram[1] = 16'h1234;

        // Reset and free-run latency.
        tick();
        tick();
        rst = 1'b0;
        wait_valid(10, n);
        chk("lat_reset", 64'(n), 64'd4);
        chk("first_instr", 64'({instr_op, instr_arg, instr_imm, instr_pc}),
            64'({8'h04, 8'h05, 16'h1234, 10'd0}));
        tick();
        chk("gap_valid", 64'(instr_valid), 64'd0);
        tick();
        chk("second_pc", 64'({instr_valid, instr_pc}), 64'({1'b1, 10'd2}));

        // Backpressure: queue fills with pcs 0 and 2 then issue stalls.
        instr_ready = 1'b0;
        do_reset();
        for (int i = 1; i <= 10; i++) begin
            tick();
            if (i >= 4) chk("bp_valid", 64'({instr_valid, instr_pc}), 64'({1'b1, 10'd0}));
            if (i >= 5) chk("bp_enb", 64'(enb), 64'd0);
        end
        instr_ready = 1'b1;
        n_deliv = 0;
        for (int i = 0; i < 12; i++) tick();
        chk("bp_deliv", 64'(n_deliv >= 3), 64'd1);

        // Redirect with pcs 4-5 in flight.
        do_reset();
        for (int i = 0; i < 6; i++) tick();
        redirect = 1'b1; redirect_addr = 10'h100;
        tick();
        redirect = 1'b0;
        wait_valid(8, n);
        chk("lat_redir", 64'(n), 64'd3);
        chk("redir_pc", 64'(instr_pc), 64'h100);

        // Back-to-back redirect: only the second target is delivered.
        redirect = 1'b1; redirect_addr = 10'h010;
        tick();
        redirect_addr = 10'h020;
        tick();
        redirect = 1'b0;
        wait_valid(8, n);
        chk("lat_b2b", 64'(n), 64'd3);
        chk("b2b_pc", 64'(instr_pc), 64'h020);

        // Instruction straddling the address wrap.
        ram[1023] = 16'h0203;
        ram[0]    = 16'h0055;
        redirect = 1'b1; redirect_addr = 10'd1023;
        tick();
        redirect = 1'b0;
        wait_valid(8, n);
        chk("lat_wrap", 64'(n), 64'd3);
        chk("wrap_instr", 64'({instr_op, instr_arg, instr_imm, instr_pc}),
            64'({8'h02, 8'h03, 16'h0055, 10'd1023}));
        tick();
        wait_valid(8, n);
        chk("wrap_next_pc", 64'(instr_pc), 64'd1);

        // Reset while an instruction is queued and reads are in flight.
        instr_ready = 1'b0;
        do_reset();
        for (int i = 0; i < 5; i++) tick();
        chk("mid_queued", 64'(instr_valid), 64'd1);
        do_reset();
        instr_ready = 1'b1;
        wait_valid(10, n);
        chk("lat_mid_rst", 64'(n), 64'd4);
        chk("mid_rst_pc", 64'(instr_pc), 64'(RESET_PC));

        // Randomized traffic.
        n_deliv = 0;
        for (int i = 0; i < 3000; i++) begin
            instr_ready   = ($urandom_range(0, 9) < 7);
            redirect      = ($urandom_range(0, 29) == 0);
            redirect_addr = ADDR_W'($urandom_range(0, (1 << ADDR_W) - 1));
            rst           = ($urandom_range(0, 299) == 0);
            tick();
        end
        rst = 1'b0; redirect = 1'b0;
        chk("rand_deliv", 64'(n_deliv > 200), 64'd1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
